// File: rtl/sf_tester_seq_pkg.sv
// Shared types, constants and pattern lookup for the flash tester iteration sequencer.
package sf_tester_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ERASE_START,
        ST_ERASE_ARM,
        ST_ERASE_WAIT,
        ST_ERASE_NEXT,
        ST_PAGE_FILL,
        ST_PAGE_START,
        ST_PAGE_ARM,
        ST_PAGE_WAIT,
        ST_PAGE_NEXT,
        ST_READ_START,
        ST_READ_ARM,
        ST_READ_WAIT,
        ST_READ_NEXT,
        ST_DONE
    } t_seq_state;

    localparam int unsigned c_subsector_bytes = 4096;
    localparam int unsigned c_page_bytes      = 256;

    localparam logic [7:0] c_pat_a_start = 8'h00;
    localparam logic [7:0] c_pat_a_incr  = 8'h01;
    localparam logic [7:0] c_pat_b_start = 8'h08;
    localparam logic [7:0] c_pat_b_incr  = 8'h07;
    localparam logic [7:0] c_pat_c_start = 8'h10;
    localparam logic [7:0] c_pat_c_incr  = 8'h0F;
    localparam logic [7:0] c_pat_d_start = 8'h18;
    localparam logic [7:0] c_pat_d_incr  = 8'h17;

    typedef struct packed {
        logic [7:0] start;
        logic [7:0] incr;
    } t_pattern;

    // Map the 2-bit pattern select onto its start/increment pair.
    function automatic t_pattern fn_pattern_sel(input logic [1:0] sel);
        t_pattern p;
        case (sel)
            2'd0:    p = '{start: c_pat_a_start, incr: c_pat_a_incr};
            2'd1:    p = '{start: c_pat_b_start, incr: c_pat_b_incr};
            2'd2:    p = '{start: c_pat_c_start, incr: c_pat_c_incr};
            default: p = '{start: c_pat_d_start, incr: c_pat_d_incr};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sf_pattern_gen.sv
// 8-bit start/increment accumulator; one instance serves both the program and verify phases.
module sf_pattern_gen (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_start,
    input  logic [7:0] i_incr,
    input  logic       i_advance,
    output logic [7:0] o_value
);

    logic [7:0] value_q;

    // Load restarts the sequence; advance steps it by the increment (mod 256).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value_q <= 8'h00;
        end else if (i_load) begin
            value_q <= i_start;
        end else if (i_advance) begin
            value_q <= value_q + i_incr;
        end
    end

    assign o_value = value_q;

endmodule

// File: rtl/sf_tester_iter_sequencer.sv
// One tester iteration: erase subsectors, program pages with a pattern, read back and verify.
//
// state           | meaning
// ST_IDLE         | waiting for a start pulse
// ST_ERASE_START  | wait for driver idle, then issue subsector erase
// ST_ERASE_ARM    | erase pulse on the bus; driver idle ignored
// ST_ERASE_WAIT   | wait for erase to complete
// ST_ERASE_NEXT   | step subsector counter or move to programming
// ST_PAGE_FILL    | push 256 pattern bytes into the driver TX FIFO
// ST_PAGE_START   | wait for driver idle, then issue page program
// ST_PAGE_ARM     | program pulse on the bus; driver idle ignored
// ST_PAGE_WAIT    | wait for program to complete
// ST_PAGE_NEXT    | step page counter or move to read-back
// ST_READ_START   | wait for driver idle, then issue page read
// ST_READ_ARM     | read pulse on the bus; read bytes already accepted
// ST_READ_WAIT    | collect 256 bytes and wait for driver idle
// ST_READ_NEXT    | step page counter or finish
// ST_DONE         | one-cycle done pulse, pass/fail published
module sf_tester_iter_sequencer
    import sf_tester_seq_pkg::*;
#(
    parameter int SUBSECTOR_CNT = 256,
    parameter int PAGE_CNT      = 4096
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rst_20mhz,
    input  logic        i_start,
    input  logic [1:0]  i_pattern_sel,
    input  logic [31:0] i_start_addr,
    input  logic        i_cmd_idle,
    output logic        o_cmd_erase_subsec,
    output logic        o_cmd_page_program,
    output logic        o_cmd_random_read,
    output logic [31:0] o_cmd_address,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [23:0] o_err_count
);

    localparam logic [8:0]  c_last_byte = 9'(c_page_bytes - 1);
    localparam logic [8:0]  c_full_page = 9'(c_page_bytes);
    localparam logic [31:0] c_last_sub  = 32'(SUBSECTOR_CNT - 1);
    localparam logic [31:0] c_last_page = 32'(PAGE_CNT - 1);
    localparam logic [23:0] c_err_max   = 24'hFF_FFFF;

    t_seq_state  state_q, state_d;
    logic [31:0] base_q;
    t_pattern    pat_q;
    logic [31:0] sub_cnt_q;
    logic [31:0] page_cnt_q;
    logic [8:0]  byte_cnt_q;
    logic [31:0] addr_q;
    logic [23:0] err_q;
    logic        pass_q;

    logic        accept_start;
    logic        tx_fire;
    logic        rx_take;
    logic        pat_load;
    logic        sub_last;
    logic        page_last;
    logic [7:0]  pat_value;

    assign accept_start = (state_q == ST_IDLE) && i_start;
    assign tx_fire      = (state_q == ST_PAGE_FILL) && i_tx_ready;
    // Read bytes count from the arm cycle on; bytes beyond a full page are dropped.
    assign rx_take      = ((state_q == ST_READ_ARM) || (state_q == ST_READ_WAIT))
                          && i_rx_valid && (byte_cnt_q != c_full_page);
    assign sub_last     = (sub_cnt_q == c_last_sub);
    assign page_last    = (page_cnt_q == c_last_page);

    sf_pattern_gen u_pattern_gen (
        .i_clk     (i_clk_20mhz),
        .i_rst     (i_rst_20mhz),
        .i_load    (pat_load),
        .i_start   (pat_q.start),
        .i_incr    (pat_q.incr),
        .i_advance (tx_fire | rx_take),
        .o_value   (pat_value)
    );

    // State register.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the pattern is reloaded on entry to the program and read phases.
    always_comb begin
        state_d  = state_q;
        pat_load = 1'b0;
        case (state_q)
            ST_IDLE:        if (i_start) state_d = ST_ERASE_START;
            ST_ERASE_START: if (i_cmd_idle) state_d = ST_ERASE_ARM;
            ST_ERASE_ARM:   state_d = ST_ERASE_WAIT;
            ST_ERASE_WAIT:  if (i_cmd_idle) state_d = ST_ERASE_NEXT;
            ST_ERASE_NEXT: begin
                if (sub_last) begin
                    state_d  = ST_PAGE_FILL;
                    pat_load = 1'b1;
                end else begin
                    state_d = ST_ERASE_START;
                end
            end
            ST_PAGE_FILL:   if (tx_fire && (byte_cnt_q == c_last_byte)) state_d = ST_PAGE_START;
            ST_PAGE_START:  if (i_cmd_idle) state_d = ST_PAGE_ARM;
            ST_PAGE_ARM:    state_d = ST_PAGE_WAIT;
            ST_PAGE_WAIT:   if (i_cmd_idle) state_d = ST_PAGE_NEXT;
            ST_PAGE_NEXT: begin
                if (page_last) begin
                    state_d  = ST_READ_START;
                    pat_load = 1'b1;
                end else begin
                    state_d = ST_PAGE_FILL;
                end
            end
            ST_READ_START:  if (i_cmd_idle) state_d = ST_READ_ARM;
            ST_READ_ARM:    state_d = ST_READ_WAIT;
            ST_READ_WAIT:   if (i_cmd_idle && (byte_cnt_q == c_full_page)) state_d = ST_READ_NEXT;
            ST_READ_NEXT:   state_d = page_last ? ST_DONE : ST_READ_START;
            ST_DONE:        state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // Datapath: iteration parameters, loop counters, command address and verify results.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            base_q     <= 32'h0;
            pat_q      <= '0;
            sub_cnt_q  <= 32'h0;
            page_cnt_q <= 32'h0;
            byte_cnt_q <= 9'h0;
            addr_q     <= 32'h0;
            err_q      <= 24'h0;
            pass_q     <= 1'b0;
        end else begin
            if (accept_start) begin
                base_q     <= i_start_addr;
                pat_q      <= fn_pattern_sel(i_pattern_sel);
                sub_cnt_q  <= 32'h0;
                page_cnt_q <= 32'h0;
                byte_cnt_q <= 9'h0;
                err_q      <= 24'h0;
                pass_q     <= 1'b0;
            end

            // Address is registered on the START->ARM step so it is stable under the pulse.
            if (i_cmd_idle) begin
                if (state_q == ST_ERASE_START) begin
                    addr_q <= base_q + sub_cnt_q * c_subsector_bytes;
                end else if ((state_q == ST_PAGE_START) || (state_q == ST_READ_START)) begin
                    addr_q <= base_q + page_cnt_q * c_page_bytes;
                end
            end

            if (state_q == ST_ERASE_NEXT) begin
                sub_cnt_q <= sub_last ? 32'h0 : sub_cnt_q + 32'h1;
            end

            if ((state_q == ST_PAGE_NEXT) || (state_q == ST_READ_NEXT)) begin
                page_cnt_q <= page_last ? 32'h0 : page_cnt_q + 32'h1;
            end

            if (tx_fire) begin
                byte_cnt_q <= (byte_cnt_q == c_last_byte) ? 9'h0 : byte_cnt_q + 9'h1;
            end

            if (rx_take) begin
                byte_cnt_q <= byte_cnt_q + 9'h1;
                if ((i_rx_data != pat_value) && (err_q != c_err_max)) begin
                    err_q <= err_q + 24'h1;
                end
            end

            if (state_q == ST_READ_NEXT) begin
                byte_cnt_q <= 9'h0;
                if (page_last) begin
                    pass_q <= (err_q == 24'h0);
                end
            end
        end
    end

    assign o_cmd_erase_subsec = (state_q == ST_ERASE_ARM);
    assign o_cmd_page_program = (state_q == ST_PAGE_ARM);
    assign o_cmd_random_read  = (state_q == ST_READ_ARM);
    assign o_cmd_address      = addr_q;
    assign o_tx_valid         = (state_q == ST_PAGE_FILL);
    assign o_tx_data          = o_tx_valid ? pat_value : 8'h00;
    assign o_busy             = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done             = (state_q == ST_DONE);
    assign o_pass             = pass_q;
    assign o_err_count        = err_q;

endmodule
